alu_mult_ctrl: RTL and testbench
================================

ALU_MULT_CTRL -- requirements
Module: alu_mult_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits; only 32 is supported.
REQ-002 SHALL have port CLK, input, 1, single clock; all state on rising edge.
REQ-003 SHALL have port RST_N, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port START, input, 1, request to begin a multiply; sampled only in IDLE.
REQ-005 SHALL have port A, input, 32, multiplicand, unsigned; captured when START is accepted.
REQ-006 SHALL have port B, input, 32, multiplier, unsigned; captured when START is accepted.
REQ-007 SHALL have port BUSY, output, 1, high while iterating.
REQ-008 SHALL have port DONE, output, 1, one-cycle pulse when HI/LO are final.
REQ-009 SHALL have port HI, output, 32, upper half of the 64-bit product.
REQ-010 SHALL have port LO, output, 32, lower half of the 64-bit product.
REQ-011 SHALL have port ALU_OP, output, 3, opcode to the shared alu_32 instance.
REQ-012 SHALL have port ALU_A, output, 32, ALU operand A.
REQ-013 SHALL have port ALU_B, output, 32, ALU operand B.
REQ-014 SHALL have port ALU_C_I, output, 1, ALU carry-in.
REQ-015 SHALL have port ALU_R, input, 32, ALU result.
REQ-016 SHALL have port ALU_C_O, input, 1, ALU adder carry-out.

Function
REQ-017 SHALL implement an FSM with states IDLE, RUN and FIN.
REQ-018 SHALL, in IDLE with START=1, on that edge load HI=0, LO=B, MCAND=A, iteration count=0, and go to RUN.
REQ-019 SHALL ignore START in RUN and FIN; the operands in flight are unaffected.
REQ-020 SHALL drive ALU_OP=000 (add), ALU_C_I=0, ALU_A=HI and ALU_B=(LO[0] ? MCAND : 0) in RUN.
REQ-021 SHALL, on each RUN edge, update {HI,LO} <= {ALU_C_O, ALU_R, LO[31:1]} and increment the iteration count.
REQ-022 SHALL use a 33-bit add via ALU_C_O, so there is no overflow loss.
REQ-023 SHALL perform exactly 32 iterations, then go RUN->FIN on the 32nd RUN edge.
REQ-024 SHALL assert DONE for exactly the one cycle spent in FIN, then go FIN->IDLE unconditionally.
REQ-025 SHALL give a latency of 33 cycles from the START-accept edge to the DONE-high cycle, independent of operand values.
REQ-026 SHALL assert BUSY exactly while in RUN, and deassert it in IDLE and FIN.
REQ-027 SHALL hold HI/LO stable from FIN until the next accepted START; HI/LO show partial values during RUN.
REQ-028 SHALL drive ALU_A=ALU_B=0, ALU_OP=000 and ALU_C_I=0 outside RUN, so the ALU can be muxed to other users.
REQ-029 SHALL accept a START asserted in the first IDLE cycle after FIN, giving back-to-back operation with one idle cycle.

Reset
REQ-030 SHALL, on RST_N low at any time including mid-RUN, immediately force state=IDLE, BUSY=0, DONE=0, HI=0, LO=0, MCAND=0 and count=0.
REQ-031 SHALL, after RST_N deasserts, accept START no earlier than the first rising CLK edge with RST_N high.
REQ-032 SHALL NOT issue a DONE for an operation aborted by reset.

Structure
REQ-033 SHALL take the FSM state encoding (IDLE=00, RUN=01, FIN=10), the opcode constant ALU_OP_ADD=3'b000 and the iteration count 32 from the shared package alu_pkg.
REQ-034 SHALL NOT instantiate alu_32; the top level connects the ALU_* ports to the shared alu_32 instance.
REQ-035 SHALL contain no sub-module; the 6-bit iteration counter is inline.

Verification
REQ-036 SHALL verify: A=3, B=5, START pulse -> DONE in cycle 33, HI=0, LO=15, BUSY high for 32 cycles.
REQ-037 SHALL verify: A=B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
REQ-038 SHALL verify: A=0x80000000, B=2 -> HI=0x00000001, LO=0x00000000.
REQ-039 SHALL verify: START held high with new A/B during RUN -> first result unchanged, no second DONE until re-accepted in IDLE.
REQ-040 SHALL verify: RST_N pulsed low at iteration 10 -> all outputs 0 asynchronously, no DONE; then A=7, B=6 -> LO=42.
REQ-041 SHALL verify: ALU_* outputs are 0 outside RUN and ALU_OP=000 in RUN, checked against the alu_32 model every cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode constants, the multiplier FSM encoding and the
// shift-add iteration count used by alu_mult_ctrl.
package alu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIN  = 2'b10
    } mult_state_e;

    localparam logic [2:0] ALU_OP_ADD = 3'b000;
    localparam int         MULT_ITERS = 32;

endpackage

// File: rtl/alu_mult_ctrl.sv
// Sequential 32x32 unsigned shift-add multiplier that borrows a shared alu_32
// for its partial-product adds; one iteration per clock, 33-cycle latency.
module alu_mult_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic [2:0]       ALU_OP,
    output logic [WIDTH-1:0] ALU_A,
    output logic [WIDTH-1:0] ALU_B,
    output logic             ALU_C_I,
    input  logic [WIDTH-1:0] ALU_R,
    input  logic             ALU_C_O
);

    localparam logic [5:0] LAST_ITER = 6'(MULT_ITERS - 1);

    mult_state_e      state_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] mcand_q;
    logic [5:0]       cnt_q;
    logic [WIDTH-1:0] hi_d;
    logic [WIDTH-1:0] lo_d;
    logic             run;

    assign run = (state_q == ST_RUN);

    // The ALU carry-out becomes the new HI MSB, so the 33-bit sum is never truncated.
    assign {hi_d, lo_d} = {ALU_C_O, ALU_R, lo_q[WIDTH-1:1]};

    // Outside RUN the ALU port is parked at zero so other users can mux onto it.
    assign ALU_OP  = ALU_OP_ADD;
    assign ALU_C_I = 1'b0;
    assign ALU_A   = run ? hi_q : '0;
    assign ALU_B   = (run && lo_q[0]) ? mcand_q : '0;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            mcand_q <= '0;
            cnt_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (START) begin
                        hi_q    <= '0;
                        lo_q    <= B;
                        mcand_q <= A;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    hi_q  <= hi_d;
                    lo_q  <= lo_d;
                    cnt_q <= cnt_q + 6'd1;
                    if (cnt_q == LAST_ITER) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign BUSY = busy_q;
    assign DONE = done_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_alu_mult_ctrl.sv
// Bench for alu_mult_ctrl: behavioural alu_32 model on the ALU port, directed
// corner operands, random operands, START-held and mid-run reset scenarios.
module tb_alu_mult_ctrl;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        START = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        BUSY;
    logic        DONE;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [2:0]  ALU_OP;
    logic [31:0] ALU_A;
    logic [31:0] ALU_B;
    logic        ALU_C_I;
    logic [31:0] ALU_R;
    logic        ALU_C_O;

    int          n_chk = 0;
    int          n_bad = 0;
    bit          have_prev = 1'b0;
    logic [63:0] prev = '0;

    always #5 CLK = ~CLK;

    // alu_32 model: only the add opcode is exercised by this block
    logic [32:0] alu_sum;
    assign alu_sum = (ALU_OP == 3'b000) ? ({1'b0, ALU_A} + {1'b0, ALU_B} + {32'd0, ALU_C_I}) : 33'd0;
    assign ALU_R   = alu_sum[31:0];
    assign ALU_C_O = alu_sum[32];

    alu_mult_ctrl #(.WIDTH(32)) dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .A(A), .B(B),
        .BUSY(BUSY), .DONE(DONE), .HI(HI), .LO(LO),
        .ALU_OP(ALU_OP), .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_C_I(ALU_C_I),
        .ALU_R(ALU_R), .ALU_C_O(ALU_C_O)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Runs one multiply starting from IDLE and returns at the negedge of the DONE cycle.
    task automatic do_mult(input logic [31:0] a, input logic [31:0] b, input bit hold, input string tag);
        logic [63:0] prod;
        int          busy_err;
        int          done_err;
        int          alu_err;
        int          busy_cnt;
        logic        eb;
        logic        ed;
        prod     = 64'(a) * 64'(b);
        busy_err = 0;
        done_err = 0;
        alu_err  = 0;
        busy_cnt = 0;
        @(negedge CLK);
        if (have_prev) chk({tag, "_held"}, {HI, LO}, prev);
        chk({tag, "_idle"}, {62'd0, BUSY, DONE}, 64'd0);
        chk({tag, "_idle_alu"}, {ALU_A, ALU_B}, 64'd0);
        A = a;
        B = b;
        START = 1'b1;
        @(posedge CLK);
        #1;
        if (!hold) START = 1'b0;
        for (int cyc = 1; cyc <= 33; cyc++) begin
            @(negedge CLK);
            eb = (cyc <= 32);
            ed = (cyc == 33);
            if (BUSY) busy_cnt++;
            if (BUSY !== eb) busy_err++;
            if (DONE !== ed) done_err++;
            if (eb) begin
                if (ALU_OP !== 3'b000 || ALU_C_I !== 1'b0 || ALU_A !== HI ||
                    ALU_B !== (LO[0] ? a : 32'd0)) alu_err++;
            end else begin
                if (ALU_OP !== 3'b000 || ALU_C_I !== 1'b0 || ALU_A !== 32'd0 ||
                    ALU_B !== 32'd0) alu_err++;
            end
            if (hold) begin
                A = $urandom;
                B = $urandom;
                START = (cyc < 33);
            end
        end
        chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd32);
        chk({tag, "_busy_err"}, 64'(busy_err), 64'd0);
        chk({tag, "_done_err"}, 64'(done_err), 64'd0);
        chk({tag, "_alu_err"}, 64'(alu_err), 64'd0);
        chk({tag, "_hi"}, {32'd0, HI}, {32'd0, prod[63:32]});
        chk({tag, "_lo"}, {32'd0, LO}, {32'd0, prod[31:0]});
        prev      = prod;
        have_prev = 1'b1;
    endtask

    initial begin
        int done_seen;

        // Power-on reset
        repeat (2) @(negedge CLK);
        chk("rst_hilo", {HI, LO}, 64'd0);
        chk("rst_ctl", {58'd0, BUSY, DONE, ALU_OP, ALU_C_I}, 64'd0);
        chk("rst_alu", {ALU_A, ALU_B}, 64'd0);
        RST_N = 1'b1;
        have_prev = 1'b1;
        prev = 64'd0;

        // Directed corners, back-to-back
        do_mult(32'd3, 32'd5, 1'b0, "a3b5");
        do_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "allones");
        do_mult(32'h8000_0000, 32'd2, 1'b0, "msb_x2");
        do_mult(32'd0, 32'hDEAD_BEEF, 1'b0, "zero_a");
        do_mult(32'h1234_5678, 32'd1, 1'b0, "one_b");

        // START held high with changing operands during the run
        do_mult(32'hCAFE_0001, 32'h0BAD_F00D, 1'b1, "hold");
        do_mult(32'd9, 32'd11, 1'b0, "after_hold");

        for (int i = 0; i < 6; i++) do_mult($urandom, $urandom, 1'b0, $sformatf("rnd%0d", i));

        // Reset in the middle of a run, between clock edges
        @(negedge CLK);
        A = $urandom | 32'h1;
        B = $urandom | 32'h1;
        START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        repeat (10) @(negedge CLK);
        #2;
        RST_N = 1'b0;
        #1;
        chk("midrst_hilo", {HI, LO}, 64'd0);
        chk("midrst_ctl", {58'd0, BUSY, DONE, ALU_OP, ALU_C_I}, 64'd0);
        chk("midrst_alu", {ALU_A, ALU_B}, 64'd0);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        done_seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge CLK);
            if (DONE || BUSY) done_seen++;
        end
        chk("midrst_no_done", 64'(done_seen), 64'd0);
        prev = 64'd0;
        do_mult(32'd7, 32'd6, 1'b0, "post_rst");

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
